result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/result_collector.sv | 97 +++++++++
 tb/tb_result_collector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// Collects a stream of result words into one packed matrix and hands it downstream.
// Define RESULT_COLLECTOR_ACCUM_EN to sum successive tiles into the buffer until last_i.
module result_collector #(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  localparam int num_words     = array_width_p * array_height_p,
  localparam int count_width   = $clog2(num_words + 1)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           en_i,
  input  logic                           valid_i,
  input  logic [width_p-1:0]             data_i,
  output logic                           yumi_o,
  input  logic                           last_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [width_p*num_words-1:0]   data_o,
  output logic [count_width-1:0]         count_o
);

  typedef enum logic {COLLECT, DONE} state_t;

  localparam logic [count_width-1:0] last_idx = count_width'(num_words - 1);

  state_t                 state, next_state;
  logic [width_p-1:0]     slots [num_words];
  logic [count_width-1:0] count;
  logic                   complete;
  logic                   release_matrix;
  logic                   finish_matrix;

  always_comb begin
    yumi_o         = en_i & valid_i & (state == COLLECT);
    complete       = yumi_o & (count == last_idx);
    release_matrix = en_i & ready_i & (state == DONE);
  end

`ifdef RESULT_COLLECTOR_ACCUM_EN
  assign finish_matrix = complete & last_i;
`else
  logic unused_last;
  assign unused_last   = last_i;
  assign finish_matrix = complete;
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= COLLECT;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      COLLECT: if (finish_matrix)  next_state = DONE;
      DONE:    if (release_matrix) next_state = COLLECT;
      default:                     next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count <= '0;
    end else if (yumi_o) begin
      count <= complete ? '0 : count + 1'b1;
    end
  end

  // Slot select by comparison keeps the index free of width mismatches for any array size.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned k = 0; k < num_words; k++) slots[k] <= '0;
    end else if (release_matrix) begin
      for (int unsigned k = 0; k < num_words; k++) slots[k] <= '0;
    end else if (yumi_o) begin
      for (int unsigned k = 0; k < num_words; k++) begin
        if (count == count_width'(k)) begin
`ifdef RESULT_COLLECTOR_ACCUM_EN
          slots[k] <= slots[k] + data_i;
`else
          slots[k] <= data_i;
`endif
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < num_words; k++) data_o[k*width_p +: width_p] = slots[k];
  end

  assign valid_o = (state == DONE);
  assign count_o = count;

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector, 32-bit words on a 2x2 array.
module tb_result_collector;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         valid_in;
  logic [31:0]  data_in;
  logic         yumi;
  logic         last;
  logic         valid_out;
  logic         ready;
  logic [127:0] data_out;
  logic [2:0]   count;

  int compared;
  int mismatched;

  result_collector #(
    .width_p       (32),
    .array_width_p (2),
    .array_height_p(2)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .en_i     (en),
    .valid_i  (valid_in),
    .data_i   (data_in),
    .yumi_o   (yumi),
    .last_i   (last),
    .valid_o  (valid_out),
    .ready_i  (ready),
    .data_o   (data_out),
    .count_o  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge: present a word, check it is taken, advance one cycle.
  task automatic send(input logic [31:0] word, input logic lst, input logic [2:0] exp_count);
    valid_in = 1'b1;
    data_in  = word;
    last     = lst;
    #1;
    chk("send_yumi", yumi, 1'b1);
    chk("send_count", count, exp_count);
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    en         = 1'b0;
    valid_in   = 1'b0;
    data_in    = '0;
    last       = 1'b0;
    ready      = 1'b0;

    #3;
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_data", data_out, 128'd0);
    chk("rst_yumi", yumi, 1'b0);

    // Basic matrix, downstream always ready
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    send(32'd1, 1'b1, 3'd0);
    send(32'd2, 1'b1, 3'd1);
    send(32'd3, 1'b1, 3'd2);
    send(32'd4, 1'b1, 3'd3);
    valid_in = 1'b0;
    chk("m1_valid", valid_out, 1'b1);
    chk("m1_data", data_out, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("m1_count", count, 3'd0);
    chk("m1_yumi", yumi, 1'b0);
    @(negedge clk);
    chk("m1_drain_valid", valid_out, 1'b0);
    chk("m1_drain_data", data_out, 128'd0);

    // Backpressure: matrix held while ready is low, upstream word stalled
    ready = 1'b0;
    send(32'd1, 1'b1, 3'd0);
    send(32'd2, 1'b1, 3'd1);
    send(32'd3, 1'b1, 3'd2);
    send(32'd4, 1'b1, 3'd3);
    valid_in = 1'b1;
    data_in  = 32'd99;
    repeat (5) begin
      #1;
      chk("bp_valid", valid_out, 1'b1);
      chk("bp_yumi", yumi, 1'b0);
      chk("bp_data", data_out, {32'd4, 32'd3, 32'd2, 32'd1});
      @(negedge clk);
    end
    ready = 1'b1;
    #1;
    chk("bp_handshake_yumi", yumi, 1'b0);
    @(negedge clk);
    chk("bp_released_valid", valid_out, 1'b0);
    send(32'd99, 1'b1, 3'd0);
    send(32'd100, 1'b1, 3'd1);

    // Asynchronous reset mid-matrix discards the partial words
    valid_in = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mid_rst_valid", valid_out, 1'b0);
    chk("mid_rst_count", count, 3'd0);
    chk("mid_rst_data", data_out, 128'd0);
    #1;
    rst_n = 1'b1;
    send(32'd5, 1'b1, 3'd0);
    send(32'd6, 1'b1, 3'd1);
    send(32'd7, 1'b1, 3'd2);
    send(32'd8, 1'b1, 3'd3);
    valid_in = 1'b0;
    chk("post_rst_valid", valid_out, 1'b1);
    chk("post_rst_data", data_out, {32'd8, 32'd7, 32'd6, 32'd5});

    // Enable low in DONE holds the matrix even with ready high
    en = 1'b0;
    @(negedge clk);
    chk("done_en_low_valid", valid_out, 1'b1);
    chk("done_en_low_data", data_out, {32'd8, 32'd7, 32'd6, 32'd5});
    en = 1'b1;
    @(negedge clk);
    chk("done_en_high_valid", valid_out, 1'b0);

    // Enable gap between words 2 and 3
    send(32'd1, 1'b1, 3'd0);
    send(32'd2, 1'b1, 3'd1);
    en       = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'd77;
    repeat (3) begin
      #1;
      chk("gap_yumi", yumi, 1'b0);
      chk("gap_count", count, 3'd2);
      @(negedge clk);
    end
    en = 1'b1;
    send(32'd3, 1'b1, 3'd2);
    send(32'd4, 1'b1, 3'd3);
    valid_in = 1'b0;
    chk("gap_valid", valid_out, 1'b1);
    chk("gap_data", data_out, {32'd4, 32'd3, 32'd2, 32'd1});
    @(negedge clk);
    chk("gap_drain_valid", valid_out, 1'b0);

`ifdef RESULT_COLLECTOR_ACCUM_EN
    // Two tiles summed; only the tile flagged last releases the matrix
    send(32'd1, 1'b0, 3'd0);
    send(32'd2, 1'b0, 3'd1);
    send(32'd3, 1'b0, 3'd2);
    send(32'd4, 1'b0, 3'd3);
    valid_in = 1'b0;
    chk("acc_tile1_valid", valid_out, 1'b0);
    chk("acc_tile1_count", count, 3'd0);
    chk("acc_tile1_data", data_out, {32'd4, 32'd3, 32'd2, 32'd1});
    send(32'd10, 1'b0, 3'd0);
    send(32'd20, 1'b0, 3'd1);
    send(32'd30, 1'b0, 3'd2);
    send(32'd40, 1'b1, 3'd3);
    valid_in = 1'b0;
    chk("acc_valid", valid_out, 1'b1);
    chk("acc_data", data_out, {32'd44, 32'd33, 32'd22, 32'd11});
    @(negedge clk);
    chk("acc_drain_valid", valid_out, 1'b0);

    // Modular wrap on accumulation
    send(32'hFFFF_FFFF, 1'b0, 3'd0);
    send(32'd0, 1'b0, 3'd1);
    send(32'd0, 1'b0, 3'd2);
    send(32'd0, 1'b0, 3'd3);
    send(32'd2, 1'b0, 3'd0);
    send(32'd0, 1'b0, 3'd1);
    send(32'd0, 1'b0, 3'd2);
    send(32'd0, 1'b1, 3'd3);
    valid_in = 1'b0;
    chk("wrap_valid", valid_out, 1'b1);
    chk("wrap_data", data_out, {32'd0, 32'd0, 32'd0, 32'd1});
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
